// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the multiplier is exhausted.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_div;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_rs;
    logic [WIDTH-1:0]   r_b;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_early;
    logic               w_last;
    logic [WIDTH:0]     w_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;

    // Unsigned ops latch raw operands: sign bits forced to zero.
    assign w_sa    = ~op[0] & rs_val[WIDTH-1];
    assign w_sb    = ~op[0] & rt_val[WIDTH-1];
    assign w_abs_a = w_sa ? -rs_val : rs_val;
    assign w_abs_b = w_sb ? -rt_val : rt_val;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = ~r_div & (r_b[WIDTH-1:1] == '0);
`else
    assign w_early = 1'b0;
`endif
    assign w_last  = (r_cnt == CW'(WIDTH - 1)) | w_early;

    // Restoring divide step on the shifted partial remainder.
    assign w_sh    = {r_rem, r_q[WIDTH-1]};
    assign w_ge    = w_sh >= {1'b0, r_b};
    assign w_diff  = w_sh[WIDTH-1:0] - r_b;

    assign w_neg    = r_sa ^ r_sb;
    assign w_prod_s = w_neg ? -r_prod : r_prod;

    always_comb begin
        w_hi = '0;
        w_lo = '0;
        if (!r_div) begin
            {w_hi, w_lo} = w_prod_s;
        end else if (r_b == '0) begin
            w_hi = r_rs;
            w_lo = '1;
        end else begin
            w_lo = w_neg ? -r_q : r_q;
            w_hi = r_sa ? -r_rem : r_rem;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = r_state != S_IDLE;
        stall = busy & rd_hilo;
        done  = r_done;
        hi    = r_hi;
        lo    = r_lo;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div   <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_rs    <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcand <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div   <= op[1];
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_rs    <= rs_val;
                        r_b     <= w_abs_b;
                        r_cnt   <= '0;
                        r_prod  <= '0;
                        r_mcand <= {{WIDTH{1'b0}}, w_abs_a};
                        r_q     <= w_abs_a;
                        r_rem   <= '0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (!r_div) begin
                        if (r_b[0]) r_prod <= r_prod + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                    end else begin
                        r_rem <= w_ge ? w_diff : w_sh[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_ge};
                    end
                end
                S_FIN: begin
                    r_hi <= w_hi;
                    r_lo <= w_lo;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a 64-bit arithmetic model.
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_hilo;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .rd_hilo(rd_hilo),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'd0: p = sa * sb;
            2'd1: p = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    p = {32'h0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    // Issue one op (caller at a negedge), run to done, check result and timing.
    // mode: 0 = latency must be 34, 1 = latency in 3..34, 2 = latency must be 3.
    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input int mode);
        logic [63:0] exp;
        logic [31:0] oh;
        logic [31:0] ol;
        int lat;
        bit ok;
        exp = model(o, a, b);
        oh  = hi;
        ol  = lo;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clock);
        #1;
        start  = 1'b0;
        op     = 2'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
        lat = 0;
        ok  = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (done) begin
                lat = c;
                break;
            end
            if (!busy || hi !== oh || lo !== ol) ok = 1'b0;
        end
        check({tag, "_busy_hold"}, 64'(ok), 64'd1);
        if (mode == 0)      check({tag, "_lat"}, 64'(lat), 64'd34);
        else if (mode == 2) check({tag, "_lat"}, 64'(lat), 64'd3);
        else check({tag, "_lat_rng"}, 64'(lat >= 3 && lat <= 34), 64'd1);
        check({tag, "_hilo"}, {hi, lo}, exp);
        check({tag, "_busy0"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] edge_v [4];
        logic [63:0] exp;
        int mode_mul;
        int n_done;
        bit st_ok;
        edge_v[0] = 32'h0;
        edge_v[1] = 32'h8000_0000;
        edge_v[2] = 32'hFFFF_FFFF;
        edge_v[3] = 32'h7FFF_FFFF;
`ifdef MULDIV_EARLY_OUT_EN
        mode_mul = 1;
`else
        mode_mul = 0;
`endif
        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'd0;
        rs_val  = '0;
        rt_val  = '0;
        rd_hilo = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset   = 1'b0;
        rd_hilo = 1'b0;
        @(negedge clock);

        do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, mode_mul);
        check("mult_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clock);
        check("done_1cyc", 64'(done), 64'd0);

        do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mode_mul);
        check("multu_max_val", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        do_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        // Back-to-back: issued in the done cycle of the previous op.
        do_op("divu_z", 2'd3, 32'd7, 32'd0, 0);
        check("divu_z_val", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        do_op("div_z", 2'd2, 32'hFFFF_FFF0, 32'd0, 0);
        do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_val", {hi, lo}, 64'h0000_0000_8000_0000);

        // Ignored second start and stall window.
        @(negedge clock);
        exp    = model(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        start  = 1'b1;
        op     = 2'd1;
        rs_val = 32'h1234_5678;
        rt_val = 32'h9ABC_DEF0;
        @(posedge clock);
        #1;
        start   = 1'b0;
        rd_hilo = 1'b1;
        st_ok   = 1'b1;
        n_done  = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clock);
            if (c == 5) begin
                start  = 1'b1;
                op     = 2'd3;
                rs_val = 32'd100;
                rt_val = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done) n_done++;
            if (!stall && busy) st_ok = 1'b0;
            if (!busy) break;
        end
        start = 1'b0;
        if (!done) begin
            for (int c = 0; c < 40 && !done; c++) @(negedge clock);
        end
        check("stall_run", 64'(st_ok), 64'd1);
        check("stall_done", 64'(stall), 64'd0);
        check("ign_done", 64'(done), 64'd1);
        check("ign_hilo", {hi, lo}, exp);
        rd_hilo = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("ign_one_done", 64'(n_done), 64'd0);
        check("ign_idle", 64'(busy), 64'd0);

        // Reset in cycle 10 of a divide.
        start  = 1'b1;
        op     = 2'd2;
        rs_val = 32'd1000;
        rt_val = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 10; c++) @(negedge clock);
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        reset  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("rst_no_done", 64'(n_done), 64'd0);

`ifdef MULDIV_EARLY_OUT_EN
        do_op("early", 2'd1, 32'd3, 32'd1, 2);
`else
        do_op("early", 2'd1, 32'd3, 32'd1, 0);
`endif
        check("early_val", {hi, lo}, 64'd3);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = edge_v[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rb = edge_v[$urandom_range(0, 3)];
            if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(0, 15));
            do_op("rand", ro, ra, rb, ro[1] ? 0 : mode_mul);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
